scratchpad_mem_responder: RTL
=============================

Name: scratchpad_mem_responder

Overview:
- Memory-side responder for the scratchpad's load/store port: services `sLoad`/`sStore` requests and returns `sLoad_hit`/`sLoad_row`/`load_data` beats and `sStore_hit` pulses.
- Backed by an internal row-wide memory with fixed, configurable response latency.
- Used as the scratchpad's backing store in unit/integration benches and FPGA bring-up; replaceable later by a real memory controller with the same port behaviour.

Parameters:
- WORD_W, 32, width of load/store addresses
- ROW_S_W, 2, width of row index
- NROWS, 4, rows per load request (must be <= 2**ROW_S_W)
- ROW_W, 64, width of a store row; load data is ROW_W-1 bits
- DEPTH, 256, rows of backing memory (power of two)
- LATENCY, 3, cycles from request acceptance to first response (>= 1)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- sLoad  in  1  load request, level, held by requester until last sLoad_hit
- load_addr  in  WORD_W  row address of first row of the load
- sStore  in  1  store request, level, held until sStore_hit
- store_addr  in  WORD_W  row address for the store
- store_data  in  ROW_W  row to store
- sLoad_hit  out  1  load beat valid
- sLoad_row  out  ROW_S_W  row index (0..NROWS-1) of current beat
- load_data  out  ROW_W-1  row data of current beat
- sStore_hit  out  1  one-cycle store completion pulse
- busy  out  1  request in progress (state != IDLE)

Behaviour:
- Reset (async, RST=1): state IDLE; sLoad_hit=0, sLoad_row=0, load_data=0, sStore_hit=0, busy=0; counters cleared. Memory contents not reset and retained across reset.
- One outstanding request; all outputs registered.
- FSM:
  - IDLE: sLoad=1 -> latch load_addr, wait counter=LATENCY-1, go LWAIT. Else sStore=1 -> write store_data[ROW_W-2:0] to mem[store_addr mod DEPTH] at this edge (MSB discarded), go SWAIT.
  - Simultaneous sLoad and sStore in IDLE: load wins; store stays pending and is accepted in the first IDLE cycle after the load completes.
  - LWAIT: decrement counter; at 0 go LSTREAM with beat index r=0. LATENCY=1 skips LWAIT.
  - LSTREAM: each cycle drive sLoad_hit=1, sLoad_row=r, load_data=mem[(addr+r) mod DEPTH]; r++. After beat NROWS-1 go DONE.
  - SWAIT: count LATENCY-1 cycles, then pulse sStore_hit=1 for exactly one cycle, go DONE.
  - DONE: outputs idle for one cycle (requester drops request here), then IDLE. A request still asserted in DONE is not re-sampled until IDLE.
- Timing: request seen at edge T -> first load beat or store hit visible after edge T+LATENCY; beats are contiguous through T+LATENCY+NROWS-1.
- Addresses and store data are sampled only at acceptance; changes while busy are ignored.
- Address wrap: row address computed mod DEPTH (low log2(DEPTH) bits), so a load crossing DEPTH-1 wraps to row 0.
- When sLoad_hit=0: load_data=0, sLoad_row=0.
- Requests dropped mid-operation: operation still completes (hits emitted).
- Reset mid-stream: beats stop immediately; no partial sStore_hit; an already-performed store write persists.

Optional Feature:
- SP_RESP_STALL_EN: when defined, adds input `stall` (1 bit).
  - stall=1 in LSTREAM: no beat that cycle (sLoad_hit=0) and r holds; streaming resumes at the same r when stall=0.
  - stall=1 in LWAIT/SWAIT: counter freezes.
  - Ignored in IDLE/DONE.
- When undefined: no stall port; behaviour as above with no bubbles.

Test Plan:
- Store rows 0xA0..0xA3 to addr 0x10..0x13 (one sStore each), then sLoad addr 0x10 -> each sStore_hit exactly LATENCY cycles after acceptance; load beats rows 0..3 with data 0xA0..0xA3 on 4 consecutive cycles, first beat LATENCY cycles after acceptance.
- Store with store_data MSB=1, reload -> load_data equals low ROW_W-1 bits; MSB dropped.
- sLoad addr DEPTH-2 (254) -> beats read mem[254], mem[255], mem[0], mem[1].
- sLoad and sStore raised in the same cycle -> full 4-beat load first, then store accepted in the first IDLE cycle; sStore_hit exactly once.
- RST pulsed after beat 1 of a load -> outputs 0 asynchronously, busy=0; subsequent load returns previously stored data intact.
- (SP_RESP_STALL_EN) stall=1 for 2 cycles after beat 1 -> sLoad_hit low 2 cycles, next beat has sLoad_row=2, 4 beats total.

Source files
------------

// File: rtl/scratchpad_mem_responder.sv
// Backing-store responder for the scratchpad load/store port: row-wide memory, fixed latency.
// Optional `stall` input (bubbles/freezes) is compiled in when SP_RESP_STALL_EN is defined.
module scratchpad_mem_responder #(
    parameter int WORD_W  = 32,
    parameter int ROW_S_W = 2,
    parameter int NROWS   = 4,
    parameter int ROW_W   = 64,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic               CLK,
    input  logic               RST,
`ifdef SP_RESP_STALL_EN
    input  logic               stall,
`endif
    input  logic               sLoad,
    input  logic [WORD_W-1:0]  load_addr,
    input  logic               sStore,
    input  logic [WORD_W-1:0]  store_addr,
    input  logic [ROW_W-1:0]   store_data,
    output logic               sLoad_hit,
    output logic [ROW_S_W-1:0] sLoad_row,
    output logic [ROW_W-2:0]   load_data,
    output logic               sStore_hit,
    output logic               busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    localparam int BW = ROW_S_W + 1;

    typedef enum logic [2:0] {IDLE, LWAIT, LSTREAM, SWAIT, DONE} stateT;

    stateT            state;
    logic [CW-1:0]    waitCnt;
    logic [BW-1:0]    beatIdx;
    logic [AW-1:0]    loadBase;
    logic             storeAccept;
    logic             stallInt;
    logic [ROW_W-2:0] mem [DEPTH];

`ifdef SP_RESP_STALL_EN
    assign stallInt = stall;
`else
    assign stallInt = 1'b0;
`endif

    // Only the low AW address bits and the low ROW_W-1 data bits are meaningful.
    logic unusedBits;
    assign unusedBits = ^{load_addr[WORD_W-1:AW], store_addr[WORD_W-1:AW], store_data[ROW_W-1]};

    // A simultaneous load wins; the store stays pending until the next IDLE cycle.
    assign storeAccept = (state == IDLE) && !sLoad && sStore;

    // NOTE: the memory array has no reset so it maps onto block RAM and keeps its contents across RST.
    always_ff @(posedge CLK) begin
        if (storeAccept) begin
            mem[store_addr[AW-1:0]] <= store_data[ROW_W-2:0];
        end
    end

    // NOTE: every register below uses <= so all outputs update together from pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            waitCnt    <= '0;
            beatIdx    <= '0;
            loadBase   <= '0;
            sLoad_hit  <= 1'b0;
            sLoad_row  <= '0;
            load_data  <= '0;
            sStore_hit <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sLoad) begin
                        loadBase <= load_addr[AW-1:0];
                        beatIdx  <= '0;
                        waitCnt  <= CW'(LATENCY - 1);
                        busy     <= 1'b1;
                        state    <= (LATENCY == 1) ? LSTREAM : LWAIT;
                    end else if (sStore) begin
                        waitCnt <= CW'(LATENCY - 1);
                        busy    <= 1'b1;
                        state   <= SWAIT;
                    end
                end
                LWAIT: begin
                    if (!stallInt) begin
                        waitCnt <= waitCnt - 1'b1;
                        if (waitCnt == CW'(1)) begin
                            state <= LSTREAM;
                        end
                    end
                end
                LSTREAM: begin
                    if (beatIdx == BW'(NROWS) || stallInt) begin
                        sLoad_hit <= 1'b0;
                        sLoad_row <= '0;
                        load_data <= '0;
                        if (beatIdx == BW'(NROWS)) begin
                            state <= DONE;
                        end
                    end else begin
                        sLoad_hit <= 1'b1;
                        sLoad_row <= beatIdx[ROW_S_W-1:0];
                        load_data <= mem[loadBase + AW'(beatIdx)];
                        beatIdx   <= beatIdx + 1'b1;
                    end
                end
                SWAIT: begin
                    if (sStore_hit) begin
                        sStore_hit <= 1'b0;
                        state      <= DONE;
                    end else if (!stallInt) begin
                        if (waitCnt == '0) begin
                            sStore_hit <= 1'b1;
                        end else begin
                            waitCnt <= waitCnt - 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
